wb_arbiter: RTL and testbench

- Writeback arbiter that owns the write port of the 32x32 register file: it drives `we`/`rd`/`wd`.
- Merges two result sources:
  - the single-cycle ALU path, which has no backpressure;
  - the multi-cycle load path, which uses a valid/ready handshake and is buffered in a small FIFO.
- Performs load byte/half selection and sign/zero extension.
- Exports a pending-load scoreboard mask so decode can stall on load-use hazards.

---
 rtl/wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU result path with buffered load responses
// onto the single register-file write port, with load-use scoreboard and anti-starvation hold.
module wb_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  output logic        we,
  output logic [4:0]  rd,
  output logic [31:0] wd,
  output logic [31:0] pend_mask,
  output logic        alu_hold
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  entry_t          fifo_d [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [SW-1:0]   starve_q;
  logic [SW-1:0]   starve_d;
  logic [31:0]     mask_d;
  logic [31:0]     ext_data;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            alu_go;
  logic            alu_kill;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign ld_ready = !rst && !full;
  assign push     = ld_valid && ld_ready;
  // A held ALU request is dropped so the starved load head drains.
  assign alu_go   = alu_valid && !alu_hold;
  assign pop      = !empty && !alu_go;
  assign alu_kill = alu_go && (alu_rd != 5'd0);
  assign head     = fifo_q[rd_ptr_q];

  // Load byte/half selection and extension, applied before buffering.
  always_comb begin
    byte_sel = ld_data[7:0];
    case (ld_addr_lo)
      2'd0: byte_sel = ld_data[7:0];
      2'd1: byte_sel = ld_data[15:8];
      2'd2: byte_sel = ld_data[23:16];
      2'd3: byte_sel = ld_data[31:24];
      default: byte_sel = ld_data[7:0];
    endcase
    half_sel = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
    case (ld_funct3)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext_data = {24'd0, byte_sel};
      3'b101:  ext_data = {16'd0, half_sel};
      default: ext_data = ld_data;
    endcase
  end

  // Next FIFO contents: kill older matches, retire head, then insert the new load.
  always_comb begin
    fifo_d = fifo_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alu_kill && (fifo_q[i].rd == alu_rd)) fifo_d[i].live = 1'b0;
    end
    if (pop)  fifo_d[rd_ptr_q].live = 1'b0;
    if (push) fifo_d[wr_ptr_q] = '{live: 1'b1, rd: ld_rd, data: ext_data};
    mask_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_d[i].live && (fifo_d[i].rd != 5'd0)) mask_d[fifo_d[i].rd] = 1'b1;
    end
  end

  always_comb begin
    if (empty || pop)                    starve_d = '0;
    else if (starve_q >= SW'(STARVE_MAX)) starve_d = starve_q;
    else                                 starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      alu_hold  <= 1'b0;
      pend_mask <= '0;
    end else begin
      fifo_q    <= fifo_d;
      starve_q  <= starve_d;
      alu_hold  <= (starve_d >= SW'(STARVE_MAX));
      pend_mask <= mask_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered write port; rd/wd hold their last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we <= 1'b0;
      rd <= '0;
      wd <= '0;
    end else if (alu_go) begin
      we <= (alu_rd != 5'd0);
      rd <= alu_rd;
      wd <= alu_data;
    end else if (pop) begin
      we <= head.live && (head.rd != 5'd0);
      rd <= head.rd;
      wd <= head.data;
    end else begin
      we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table for ALU/load extension,
// hand sequences for collision, backpressure, kill, starvation and reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [31:0] pend_mask;
  logic        alu_hold;

  int errors = 0;
  int checks = 0;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .we(we), .rd(rd), .wd(wd), .pend_mask(pend_mask), .alu_hold(alu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      assert (!(alu_hold && alu_valid))
      else begin
        errors++;
        $error("FAIL alu_valid presented while alu_hold");
      end
    end
  end

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic        ewe;
    logic [4:0]  erd;
    logic [31:0] ewd;
    logic [31:0] epend;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = r;
    alu_data  = d;
  endtask

  task automatic set_ld(input logic v, input logic [4:0] r, input logic [31:0] d,
                        input logic [2:0] f3, input logic [1:0] lo);
    ld_valid   = v;
    ld_rd      = r;
    ld_data    = d;
    ld_funct3  = f3;
    ld_addr_lo = lo;
  endtask

  localparam logic [31:0] D = 32'h80FF7F01;

  initial begin
    tbl[0]  = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0, 3'b000, 2'd0, 1'b1, 5'd5, 32'h12345678, 32'h0};
    tbl[1]  = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 3'b000, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd1, D, 3'b000, 2'd3, 1'b0, 5'd0, 32'h0, 32'h2};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd2, D, 3'b100, 2'd1, 1'b1, 5'd1, 32'hFFFFFF80, 32'h4};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, D, 3'b001, 2'd2, 1'b1, 5'd2, 32'h0000007F, 32'h8};
    tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, D, 3'b101, 2'd0, 1'b1, 5'd3, 32'hFFFF80FF, 32'h10};
    tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, D, 3'b010, 2'd0, 1'b1, 5'd4, 32'h00007F01, 32'h20};
    tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd6, D, 3'b001, 2'd3, 1'b1, 5'd5, 32'h80FF7F01, 32'h40};
    tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h00008001, 3'b011, 2'd0, 1'b1, 5'd6, 32'hFFFF80FF, 32'h80};
    tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, D, 3'b000, 2'd0, 1'b1, 5'd7, 32'h00008001, 32'h0};
    tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd8, D, 3'b000, 2'd1, 1'b0, 5'd0, 32'h0, 32'h100};
    tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'b000, 2'd0, 1'b1, 5'd8, 32'h0000007F, 32'h0};
    tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'b000, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0};

    rst = 1'b1;
    set_alu(1'b0, 5'd0, 32'h0);
    set_ld(1'b0, 5'd0, 32'h0, 3'b000, 2'd0);
    step();
    step();
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_rd", 32'(rd), 32'h0);
    chk("rst_wd", wd, 32'h0);
    chk("rst_pend", pend_mask, 32'h0);
    chk("rst_hold", 32'(alu_hold), 32'h0);
    chk("rst_ready", 32'(ld_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ld_ready), 32'h1);

    // Vector table: ALU path and load extension pipeline.
    for (int i = 0; i < 13; i++) begin
      set_alu(tbl[i].av, tbl[i].ard, tbl[i].adat);
      set_ld(tbl[i].lv, tbl[i].lrd, tbl[i].ldat, tbl[i].f3, tbl[i].lo);
      step();
      chk($sformatf("v%0d_we", i), 32'(we), 32'(tbl[i].ewe));
      if (tbl[i].ewe) begin
        chk($sformatf("v%0d_rd", i), 32'(rd), 32'(tbl[i].erd));
        chk($sformatf("v%0d_wd", i), wd, tbl[i].ewd);
      end
      chk($sformatf("v%0d_pend", i), pend_mask, tbl[i].epend);
      chk($sformatf("v%0d_ready", i), 32'(ld_ready), 32'h1);
      chk($sformatf("v%0d_hold", i), 32'(alu_hold), 32'h0);
    end
    set_ld(1'b0, 5'd0, 32'h0, 3'b000, 2'd0);

    // Collision: load waits behind three ALU writes.
    set_alu(1'b1, 5'd3, 32'hA0);
    set_ld(1'b1, 5'd7, 32'h11111111, 3'b010, 2'd0);
    step();
    set_ld(1'b0, 5'd0, 32'h0, 3'b000, 2'd0);
    chk("col0_rd", 32'(rd), 32'd3);
    chk("col0_wd", wd, 32'hA0);
    chk("col0_pend", pend_mask, 32'h80);
    for (int i = 1; i < 3; i++) begin
      set_alu(1'b1, 5'd3, 32'hA0 + 32'(i));
      step();
      chk($sformatf("col%0d_we", i), 32'(we), 32'h1);
      chk($sformatf("col%0d_wd", i), wd, 32'hA0 + 32'(i));
      chk($sformatf("col%0d_pend", i), pend_mask, 32'h80);
    end
    set_alu(1'b0, 5'd0, 32'h0);
    step();
    chk("col_ld_we", 32'(we), 32'h1);
    chk("col_ld_rd", 32'(rd), 32'd7);
    chk("col_ld_wd", wd, 32'h11111111);
    chk("col_ld_pend", pend_mask, 32'h0);
    step();
    chk("col_idle_we", 32'(we), 32'h0);

    // Full FIFO backpressure: third load is held until a slot frees.
    set_alu(1'b1, 5'd1, 32'hB0);
    set_ld(1'b1, 5'd10, 32'hA, 3'b010, 2'd0);
    step();
    chk("bp_ready1", 32'(ld_ready), 32'h1);
    set_ld(1'b1, 5'd11, 32'hB, 3'b010, 2'd0);
    step();
    chk("bp_full_ready", 32'(ld_ready), 32'h0);
    chk("bp_full_pend", pend_mask, 32'h0C00);
    set_ld(1'b1, 5'd12, 32'hC, 3'b010, 2'd0);
    set_alu(1'b1, 5'd1, 32'hB2);
    step();
    chk("bp_held_ready", 32'(ld_ready), 32'h0);
    chk("bp_held_wd", wd, 32'hB2);
    set_alu(1'b0, 5'd0, 32'h0);
    step();
    chk("bp_pop1_rd", 32'(rd), 32'd10);
    chk("bp_pop1_wd", wd, 32'hA);
    chk("bp_pop1_ready", 32'(ld_ready), 32'h1);
    chk("bp_pop1_pend", pend_mask, 32'h0800);
    step();
    set_ld(1'b0, 5'd0, 32'h0, 3'b000, 2'd0);
    chk("bp_pop2_rd", 32'(rd), 32'd11);
    chk("bp_pop2_wd", wd, 32'hB);
    chk("bp_pop2_pend", pend_mask, 32'h1000);
    step();
    chk("bp_pop3_we", 32'(we), 32'h1);
    chk("bp_pop3_rd", 32'(rd), 32'd12);
    chk("bp_pop3_wd", wd, 32'hC);
    chk("bp_pop3_pend", pend_mask, 32'h0);

    // Kill: younger ALU write to x9 suppresses the buffered load.
    set_alu(1'b1, 5'd2, 32'hD0);
    set_ld(1'b1, 5'd9, 32'h99, 3'b010, 2'd0);
    step();
    set_ld(1'b0, 5'd0, 32'h0, 3'b000, 2'd0);
    chk("kill_pend_set", pend_mask, 32'h200);
    set_alu(1'b1, 5'd9, 32'hD9);
    step();
    chk("kill_alu_rd", 32'(rd), 32'd9);
    chk("kill_alu_wd", wd, 32'hD9);
    chk("kill_pend_clr", pend_mask, 32'h0);
    set_alu(1'b0, 5'd0, 32'h0);
    step();
    chk("kill_pop_we", 32'(we), 32'h0);
    set_alu(1'b1, 5'd9, 32'hE9);
    set_ld(1'b1, 5'd9, 32'h77, 3'b010, 2'd0);
    step();
    set_alu(1'b0, 5'd0, 32'h0);
    set_ld(1'b0, 5'd0, 32'h0, 3'b000, 2'd0);
    chk("samecyc_wd", wd, 32'hE9);
    chk("samecyc_pend", pend_mask, 32'h200);
    step();
    chk("samecyc_ld_we", 32'(we), 32'h1);
    chk("samecyc_ld_wd", wd, 32'h77);

    // Starvation: continuous ALU traffic until alu_hold rises.
    set_alu(1'b1, 5'd4, 32'hF0);
    set_ld(1'b1, 5'd13, 32'h1313, 3'b010, 2'd0);
    step();
    set_ld(1'b0, 5'd0, 32'h0, 3'b000, 2'd0);
    begin
      int waited;
      waited = 0;
      for (int i = 1; i <= 10; i++) begin
        step();
        waited = i;
        if (alu_hold) break;
      end
      set_alu(1'b0, 5'd0, 32'h0);
      chk("starve_wait", 32'(waited), 32'd4);
      chk("starve_hold", 32'(alu_hold), 32'h1);
      chk("starve_pend", pend_mask, 32'h2000);
    end
    step();
    chk("starve_ld_we", 32'(we), 32'h1);
    chk("starve_ld_rd", 32'(rd), 32'd13);
    chk("starve_ld_wd", wd, 32'h1313);
    chk("starve_release", 32'(alu_hold), 32'h0);

    // Reset with two loads buffered.
    set_alu(1'b1, 5'd1, 32'h1);
    set_ld(1'b1, 5'd14, 32'hE, 3'b010, 2'd0);
    step();
    set_ld(1'b1, 5'd15, 32'hF, 3'b010, 2'd0);
    step();
    set_alu(1'b0, 5'd0, 32'h0);
    set_ld(1'b0, 5'd0, 32'h0, 3'b000, 2'd0);
    chk("mid_pend", pend_mask, 32'hC000);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready_c", 32'(ld_ready), 32'h0);
    step();
    chk("mid_rst_we", 32'(we), 32'h0);
    chk("mid_rst_pend", pend_mask, 32'h0);
    chk("mid_rst_ready", 32'(ld_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("after_rst_ready", 32'(ld_ready), 32'h1);
    step();
    chk("after_rst_we", 32'(we), 32'h0);
    chk("after_rst_pend", pend_mask, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
